ofs_plat_utils_mf_dcfifo_rd_stream: RTL
=======================================

OFS_PLAT_UTILS_MF_DCFIFO_RD_STREAM -- requirements
Module: ofs_plat_utils_mf_dcfifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width.
REQ-002 SHALL have parameter READ_LATENCY, default 1: cycles from fifo_rdreq high at a clk edge to fifo_q valid; legal range 1..4.
REQ-003 SHALL have localparam BUF_DEPTH = READ_LATENCY + 2: output buffer entries.
REQ-004 SHALL have port clk  input  1  read-side clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port fifo_rdempty  input  1  FIFO read-side empty.
REQ-007 SHALL have port fifo_rdreq  output  1  FIFO read request; non-showahead.
REQ-008 SHALL have port fifo_q  input  DATA_WIDTH  FIFO read data.
REQ-009 SHALL have port out_valid  output  1  stream data valid.
REQ-010 SHALL have port out_ready  input  1  stream consumer ready.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  stream payload.
REQ-012 SHALL have port out_count  output  $clog2(BUF_DEPTH+1)  entries in flight plus stored.

Function
REQ-013 SHALL assert fifo_rdreq = !fifo_rdempty && (used < BUF_DEPTH); used = in-flight reads + stored entries; fifo_rdreq has no combinational path from out_ready.
REQ-014 SHALL never assert fifo_rdreq while fifo_rdempty is high.
REQ-015 SHALL track in-flight reads with a READ_LATENCY-deep valid shift register; on exit, fifo_q is written into the buffer tail.
REQ-016 SHALL present buffer head on out_data, registered, with out_valid = (stored > 0).
REQ-017 SHALL dequeue on out_valid && out_ready; out_data/out_valid SHALL stay stable while out_valid && !out_ready.
REQ-018 SHALL update used by +1 on fifo_rdreq, -1 on dequeue, unchanged when both occur in the same cycle; out_count = used.
REQ-019 SHALL sustain one transfer per cycle with out_ready held high and FIFO non-empty, after an initial fill latency of READ_LATENCY+1 cycles.
REQ-020 SHALL handle simultaneous buffer write and dequeue, including with the buffer holding exactly one entry, without loss or duplication.
REQ-021 SHALL wrap head/tail pointers modulo BUF_DEPTH; used SHALL never exceed BUF_DEPTH, so the buffer never overflows.
REQ-022 SHALL preserve FIFO order exactly.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear used, pointers and the valid shift register, giving out_valid=0, fifo_rdreq=0 and out_count=0; out_data is don't-care.
REQ-024 SHALL discard in-flight reads and stored entries on reset mid-operation; FIFO aclr is driven externally and is not generated here.
REQ-025 SHALL issue no fifo_rdreq in the first cycle after reset_n deasserts.

Structure
REQ-026 SHALL need no shared package; BUF_DEPTH and pointer widths are local params.
REQ-027 SHALL put the storage in one sub-module, ofs_plat_utils_mf_dcfifo_rd_buf: a register-array FIFO of BUF_DEPTH entries with enq, deq, head and count.
REQ-028 SHALL place the valid shift register and credit logic in the top module.

Verification
REQ-029 Back-to-back: READ_LATENCY=1, FIFO preloaded 0..99, out_ready=1 -> first beat 0 appears 2 cycles after the first fifo_rdreq, then 100 consecutive beats 0..99 with no bubbles.
REQ-030 Backpressure: out_ready=0 for 20 cycles with the FIFO holding 10 -> fifo_rdreq stops with out_count=BUF_DEPTH=3; out_data holds value 0; releasing out_ready delivers 0..9 in order.
REQ-031 Empty gating: fifo_rdempty toggles every cycle -> fifo_rdreq is never high while fifo_rdempty is high; all words are delivered once, in order.
REQ-032 Random ready: READ_LATENCY=3, 1000 words, 50% random out_ready -> a scoreboard matches every word, out_count never exceeds 5, and out_data is stable under stall.
REQ-033 Reset mid-stream: assert reset_n low while 2 reads are in flight and 2 entries are stored -> out_valid, fifo_rdreq and out_count are 0 the same cycle; after release, the next delivered word is the FIFO's next word.
REQ-034 Single entry with simultaneous enqueue and dequeue: stored=1, out_ready=1, a read returns -> out_valid stays high and the two consecutive beats are correct.

Source files
------------

// File: rtl/ofs_plat_utils_mf_dcfifo_rd_buf.sv
// Small register-array FIFO that holds words returned by the dual-clock FIFO
// until the stream consumer takes them. The head entry is driven straight from storage.
module ofs_plat_utils_mf_dcfifo_rd_buf #(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 3,
   localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enq,
   input  logic [DATA_WIDTH-1:0] enq_data,
   input  logic                  deq,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CNT_W-1:0]      count
);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [PTR_W-1:0]                 wr_ptr;
   logic [PTR_W-1:0]                 rd_ptr;

   // DEPTH need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= enq_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= ptr_inc(wr_ptr);
         if (deq) rd_ptr <= ptr_inc(rd_ptr);
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ofs_plat_utils_mf_dcfifo_rd_stream.sv
// Turns the read side of a non-showahead dual-clock FIFO into a valid/ready stream,
// issuing reads only when the output buffer has credit for the returning word.
module ofs_plat_utils_mf_dcfifo_rd_stream #(
   parameter int  DATA_WIDTH   = 32,
   parameter int  READ_LATENCY = 1,
   localparam int BUF_DEPTH    = READ_LATENCY + 2,
   localparam int CNT_W        = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fifo_rdempty,
   output logic                  fifo_rdreq,
   input  logic [DATA_WIDTH-1:0] fifo_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      out_count
);

   logic [READ_LATENCY:1] vld_pipe;
   logic [CNT_W-1:0]      used;
   logic [CNT_W-1:0]      stored;
   logic                  rd_armed;
   logic                  deq;

   // Credit check uses only registered state, so out_ready never reaches fifo_rdreq.
   assign fifo_rdreq = rd_armed && !fifo_rdempty && (used < CNT_W'(BUF_DEPTH));
   assign deq        = out_valid && out_ready;
   assign out_valid  = (stored != '0);
   assign out_count  = used;

   // Holds off reads for the first cycle after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_armed <= 1'b0;
      else          rd_armed <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= fifo_rdreq;
         for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         used <= '0;
      end else begin
         case ({fifo_rdreq, deq})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   ofs_plat_utils_mf_dcfifo_rd_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clk      (clk),
      .reset_n  (reset_n),
      .enq      (vld_pipe[READ_LATENCY]),
      .enq_data (fifo_q),
      .deq      (deq),
      .head     (out_data),
      .count    (stored)
   );

endmodule
